// File: rtl/imem_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, drives the instruction memory address, registers the IF/ID
// boundary and time-shares the single memory read port with a debug/loader read requester.
module imem_fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          MEM_WORDS = 128
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   input  logic        DbgReq,
   input  logic [31:0] DbgAddr,
   output logic [31:0] ImemAddress,
   input  logic [31:0] ImemInstruction,
   output logic [31:0] IF_Instruction,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_PCPlus4,
   output logic        IF_Valid,
   output logic [31:0] DbgData,
   output logic        DbgValid,
   output logic        Halted
);

   localparam logic [31:0] FETCH_LIMIT = 32'(MEM_WORDS * 4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] if_instr_reg;
   logic [31:0] if_pc_reg;
   logic [31:0] if_pc4_reg;
   logic        if_valid_reg;
   logic [31:0] dbg_data_reg;
   logic        dbg_valid_reg;
   logic        halted_reg;

   logic        dbg_take;
   logic [31:0] redirect_target;

   assign redirect_target = {RedirectPC[31:2], 2'b00};

   // In RUN a debug read may not follow another one directly, so fetch always gets every other slot.
   always_comb begin
      dbg_take = 1'b0;
      case (state_reg)
         RUN:     dbg_take = DbgReq && !Redirect && !dbg_valid_reg;
         default: dbg_take = DbgReq;
      endcase
   end

   assign ImemAddress = dbg_take ? DbgAddr : pc_reg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         if_instr_reg  <= 32'h0;
         if_pc_reg     <= 32'h0;
         if_pc4_reg    <= RESET_PC + 32'd4;
         if_valid_reg  <= 1'b0;
         dbg_data_reg  <= 32'h0;
         dbg_valid_reg <= 1'b0;
         halted_reg    <= 1'b0;
      end else begin
         dbg_valid_reg <= dbg_take;
         if (dbg_take) begin
            dbg_data_reg <= ImemInstruction;
         end
         case (state_reg)
            IDLE: begin
               if (Start) begin
                  state_reg <= RUN;
               end
            end
            RUN: begin
               if (Redirect) begin
                  pc_reg       <= redirect_target;
                  if_valid_reg <= 1'b0;
               end else if (dbg_take) begin
                  if (!Stall) begin
                     if_valid_reg <= 1'b0;
                  end
               end else if (!Stall) begin
                  if (pc_reg >= FETCH_LIMIT) begin
                     state_reg    <= HALT;
                     halted_reg   <= 1'b1;
                     if_valid_reg <= 1'b0;
                  end else begin
                     if_instr_reg <= ImemInstruction;
                     if_pc_reg    <= pc_reg;
                     if_pc4_reg   <= pc_reg + 32'd4;
                     if_valid_reg <= 1'b1;
                     pc_reg       <= pc_reg + 32'd4;
                  end
               end
            end
            HALT: begin
               if (Redirect) begin
                  state_reg  <= RUN;
                  halted_reg <= 1'b0;
                  pc_reg     <= redirect_target;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign IF_Instruction = if_instr_reg;
   assign IF_PC          = if_pc_reg;
   assign IF_PCPlus4     = if_pc4_reg;
   assign IF_Valid       = if_valid_reg;
   assign DbgData        = dbg_data_reg;
   assign DbgValid       = dbg_valid_reg;
   assign Halted         = halted_reg;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench: a stimulus process queues hand-computed per-cycle expectations, a monitor pops and checks them.
module tb_imem_fetch_sequencer;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        DbgReq;
   logic [31:0] DbgAddr;
   logic [31:0] ImemAddress;
   logic [31:0] ImemInstruction;
   logic [31:0] IF_Instruction;
   logic [31:0] IF_PC;
   logic [31:0] IF_PCPlus4;
   logic        IF_Valid;
   logic [31:0] DbgData;
   logic        DbgValid;
   logic        Halted;

   imem_fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(128)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Start(Start),
      .Stall(Stall),
      .Redirect(Redirect),
      .RedirectPC(RedirectPC),
      .DbgReq(DbgReq),
      .DbgAddr(DbgAddr),
      .ImemAddress(ImemAddress),
      .ImemInstruction(ImemInstruction),
      .IF_Instruction(IF_Instruction),
      .IF_PC(IF_PC),
      .IF_PCPlus4(IF_PCPlus4),
      .IF_Valid(IF_Valid),
      .DbgData(DbgData),
      .DbgValid(DbgValid),
      .Halted(Halted)
   );

   // Instruction memory model: word i holds 0x1000+i, address bits [1:0] ignored.
   assign ImemInstruction = 32'h1000 + {25'd0, ImemAddress[8:2]};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      bit          full;
      bit          ifv;
      logic [31:0] ipc;
      logic [31:0] iins;
      bit          dv;
      logic [31:0] dd;
      bit          hl;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic step(input bit rst, input bit st, input bit sl, input bit rd,
                       input logic [31:0] rpc, input bit dq, input logic [31:0] da,
                       input bit ifv, input logic [31:0] ipc, input logic [31:0] iins,
                       input bit dv, input logic [31:0] dd, input bit hl, input bit full);
      exp_t e;
      Reset      = rst;
      Start      = st;
      Stall      = sl;
      Redirect   = rd;
      RedirectPC = rpc;
      DbgReq     = dq;
      DbgAddr    = da;
      e.due  = cyc + 1;
      e.full = full;
      e.ifv  = ifv;
      e.ipc  = ipc;
      e.iins = iins;
      e.dv   = dv;
      e.dd   = dd;
      e.hl   = hl;
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   // Monitor: checks IF_* fields when a valid instruction (or reset state) is expected, DbgData likewise.
   initial begin
      forever begin
         @(negedge Clk);
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            bit   ok;
            e  = exp_q.pop_front();
            ok = (IF_Valid == e.ifv) && (DbgValid == e.dv) && (Halted == e.hl);
            if (e.full || e.ifv)
               ok = ok && (IF_PC == e.ipc) && (IF_Instruction == e.iins) && (IF_PCPlus4 == e.ipc + 32'd4);
            if (e.full || e.dv)
               ok = ok && (DbgData == e.dd);
            total++;
            if (!ok) begin
               bad++;
               $display("FAIL cycle%0d: got v=%0b pc=%h ins=%h pc4=%h dv=%0b dd=%h h=%0b, want v=%0b pc=%h ins=%h dv=%0b dd=%h h=%0b",
                        e.due, IF_Valid, IF_PC, IF_Instruction, IF_PCPlus4, DbgValid, DbgData, Halted,
                        e.ifv, e.ipc, e.iins, e.dv, e.dd, e.hl);
            end else begin
               $display("cycle%0d ok: v=%0b pc=%h ins=%h dv=%0b dd=%h h=%0b",
                        e.due, IF_Valid, IF_PC, IF_Instruction, DbgValid, DbgData, Halted);
            end
         end
      end
   end

   initial begin
      Reset = 1'b1; Start = 1'b0; Stall = 1'b0; Redirect = 1'b0;
      RedirectPC = 32'h0; DbgReq = 1'b0; DbgAddr = 32'h0;
      #1;
      //   rst st sl rd rpc       dq da       ifv ipc      iins      dv dd        hl full
      step(1, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 1);
      step(1, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 1);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);
      step(0, 1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);
      // sequential fetch
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h0,  32'h1000, 0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h4,  32'h1001, 0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h8,  32'h1002, 0, 32'h0,    0, 0);
      // stall holds three cycles
      step(0, 0, 1, 0, 32'h0,   0, 32'h0,  1, 32'h8,  32'h1002, 0, 32'h0,    0, 0);
      step(0, 0, 1, 0, 32'h0,   0, 32'h0,  1, 32'h8,  32'h1002, 0, 32'h0,    0, 0);
      step(0, 0, 1, 0, 32'h0,   0, 32'h0,  1, 32'h8,  32'h1002, 0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'hC,  32'h1003, 0, 32'h0,    0, 0);
      // redirect with stall, unaligned target
      step(0, 0, 1, 1, 32'h23,  0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h20, 32'h1008, 0, 32'h0,    0, 0);
      // debug reads interleave with fetch
      step(0, 0, 0, 0, 32'h0,   1, 32'h10, 0, 32'h0,  32'h0,    1, 32'h1004, 0, 0);
      step(0, 0, 0, 0, 32'h0,   1, 32'h10, 1, 32'h24, 32'h1009, 0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   1, 32'h10, 0, 32'h0,  32'h0,    1, 32'h1004, 0, 0);
      step(0, 0, 0, 0, 32'h0,   1, 32'h10, 1, 32'h28, 32'h100A, 0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h2C, 32'h100B, 0, 32'h0,    0, 0);
      // end of memory
      step(0, 0, 0, 1, 32'h1F8, 0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h1F8, 32'h107E, 0, 32'h0,   0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h1FC, 32'h107F, 0, 32'h0,   0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    1, 0);
      step(0, 1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    1, 0);
      // debug back-to-back while halted
      step(0, 0, 0, 0, 32'h0,   1, 32'h0,  0, 32'h0,  32'h0,    1, 32'h1000, 1, 0);
      step(0, 0, 0, 0, 32'h0,   1, 32'h6,  0, 32'h0,  32'h0,    1, 32'h1001, 1, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    1, 0);
      // leave halt by redirect
      step(0, 0, 0, 1, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h0,  32'h1000, 0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h4,  32'h1001, 0, 32'h0,    0, 0);
      // reset in the middle of a debug read
      step(0, 0, 0, 0, 32'h0,   1, 32'h8,  0, 32'h0,  32'h0,    1, 32'h1002, 0, 0);
      step(1, 0, 0, 0, 32'h0,   1, 32'h8,  0, 32'h0,  32'h0,    0, 32'h0,    0, 1);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);
      // debug every cycle while idle
      step(0, 0, 0, 0, 32'h0,   1, 32'hC,  0, 32'h0,  32'h0,    1, 32'h1003, 0, 0);
      step(0, 0, 0, 0, 32'h0,   1, 32'hC,  0, 32'h0,  32'h0,    1, 32'h1003, 0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);
      step(0, 1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h0,  32'h1000, 0, 32'h0,    0, 0);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h4,  32'h1001, 0, 32'h0,    0, 0);
      // reset mid-run
      step(1, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 1);
      step(0, 0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h0,    0, 32'h0,    0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
